// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the Core101 stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        IMEM_WAIT = 3'd1,
        LSU_WAIT  = 3'd2,
        FLUSH     = 3'd3,
        DRAIN     = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam int FLUSH_CYCLES_DEF = 1;
    localparam int DRAIN_CYCLES_DEF = 4;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_is;
        logic is_ex;
        logic ex_wb;
    } sets_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, for perf counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the Core101 IF/ID/IS/EX/WB pipeline.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             imem_ready_in,
    input  logic             lsu_busy_in,
    input  logic             load_use_in,
    input  logic             bru_flush_in,
    input  logic             halt_req_in,
    input  logic             resume_in,
    output logic             pc_set_out,
    output logic             if_id_set_out,
    output logic             id_is_set_out,
    output logic             is_ex_set_out,
    output logic             ex_wb_set_out,
    output logic             if_id_flush_out,
    output logic             id_is_flush_out,
    output logic             is_ex_bubble_out,
    output logic             wb_kill_out,
    output logic             halted_out,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt_out
);

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);
    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    sets_t      sets;
    logic       if_id_flush;
    logic       id_is_flush;
    logic       bubble;
    logic       kill;
    logic       stall_en;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        sets        = '1;
        if_id_flush = 1'b0;
        id_is_flush = 1'b0;
        bubble      = 1'b0;
        kill        = 1'b0;
        unique case (state)
            RUN: begin
                if (bru_flush_in) begin
                    if_id_flush = 1'b1;
                    id_is_flush = 1'b1;
                    cnt_nx      = FLUSH_LD;
                    state_nx    = FLUSH;
                end else if (lsu_busy_in) begin
                    sets     = '0;
                    kill     = 1'b1;
                    state_nx = LSU_WAIT;
                end else if (load_use_in) begin
                    sets.pc    = 1'b0;
                    sets.if_id = 1'b0;
                    sets.id_is = 1'b0;
                    bubble     = 1'b1;
                end else if (!imem_ready_in) begin
                    sets.pc     = 1'b0;
                    if_id_flush = 1'b1;
                    state_nx    = IMEM_WAIT;
                end else if (halt_req_in) begin
                    cnt_nx   = DRAIN_LD;
                    state_nx = DRAIN;
                end
            end
            IMEM_WAIT: begin
                if (bru_flush_in) begin
                    if_id_flush = 1'b1;
                    id_is_flush = 1'b1;
                    cnt_nx      = FLUSH_LD;
                    state_nx    = FLUSH;
                end else if (imem_ready_in) begin
                    state_nx = RUN;
                end else begin
                    sets.pc     = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
            LSU_WAIT: begin
                if (lsu_busy_in) begin
                    sets = '0;
                    kill = 1'b1;
                end else begin
                    state_nx = RUN;
                end
            end
            FLUSH: begin
                // IFU refetches from the redirect target while IF/ID stays clear
                if_id_flush = 1'b1;
                cnt_nx      = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = RUN;
                end
            end
            DRAIN: begin
                if (bru_flush_in) begin
                    if_id_flush = 1'b1;
                    id_is_flush = 1'b1;
                    cnt_nx      = DRAIN_LD;
                end else begin
                    sets.pc     = 1'b0;
                    if_id_flush = 1'b1;
                    cnt_nx      = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_nx = HALT;
                    end
                end
            end
            HALT: begin
                sets = '0;
                kill = 1'b1;
                if (resume_in) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
        if (reset_in) begin
            sets        = '0;
            if_id_flush = 1'b1;
            id_is_flush = 1'b1;
            bubble      = 1'b0;
            kill        = 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign stall_en = (sets != '1) && (state != HALT);

    sat_counter #(.W(CNT_W)) stall_ctr (
        .clk   (clock_in),
        .clr   (reset_in),
        .en    (stall_en),
        .count (stall_cnt_out)
    );

    assign pc_set_out       = sets.pc;
    assign if_id_set_out    = sets.if_id;
    assign id_is_set_out    = sets.id_is;
    assign is_ex_set_out    = sets.is_ex;
    assign ex_wb_set_out    = sets.ex_wb;
    assign if_id_flush_out  = if_id_flush;
    assign id_is_flush_out  = id_is_flush;
    assign is_ex_bubble_out = bubble;
    assign wb_kill_out      = kill;
    assign halted_out       = (state == HALT) && !reset_in;
    assign state_out        = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a random run.
module tb_pipeline_ctrl;

    logic        clock_in;
    logic        reset_in;
    logic        imem_ready_in;
    logic        lsu_busy_in;
    logic        load_use_in;
    logic        bru_flush_in;
    logic        halt_req_in;
    logic        resume_in;
    logic        pc_set_out;
    logic        if_id_set_out;
    logic        id_is_set_out;
    logic        is_ex_set_out;
    logic        ex_wb_set_out;
    logic        if_id_flush_out;
    logic        id_is_flush_out;
    logic        is_ex_bubble_out;
    logic        wb_kill_out;
    logic        halted_out;
    logic [2:0]  state_out;
    logic [15:0] stall_cnt_out;

    logic [4:0] sets;
    logic [4:0] ctl;
    int n_cmp;
    int n_bad;

    assign sets = {pc_set_out, if_id_set_out, id_is_set_out,
                   is_ex_set_out, ex_wb_set_out};
    assign ctl  = {if_id_flush_out, id_is_flush_out, is_ex_bubble_out,
                   wb_kill_out, halted_out};

    pipeline_ctrl #(
        .FLUSH_CYCLES (2),
        .DRAIN_CYCLES (4),
        .CNT_W        (16)
    ) dut (
        .clock_in         (clock_in),
        .reset_in         (reset_in),
        .imem_ready_in    (imem_ready_in),
        .lsu_busy_in      (lsu_busy_in),
        .load_use_in      (load_use_in),
        .bru_flush_in     (bru_flush_in),
        .halt_req_in      (halt_req_in),
        .resume_in        (resume_in),
        .pc_set_out       (pc_set_out),
        .if_id_set_out    (if_id_set_out),
        .id_is_set_out    (id_is_set_out),
        .is_ex_set_out    (is_ex_set_out),
        .ex_wb_set_out    (ex_wb_set_out),
        .if_id_flush_out  (if_id_flush_out),
        .id_is_flush_out  (id_is_flush_out),
        .is_ex_bubble_out (is_ex_bubble_out),
        .wb_kill_out      (wb_kill_out),
        .halted_out       (halted_out),
        .state_out        (state_out),
        .stall_cnt_out    (stall_cnt_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic idle;
        imem_ready_in = 1'b1;
        lsu_busy_in   = 1'b0;
        load_use_in   = 1'b0;
        bru_flush_in  = 1'b0;
        halt_req_in   = 1'b0;
        resume_in     = 1'b0;
    endtask

    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask

    task automatic look;
        @(negedge clock_in);
    endtask

    task automatic do_reset;
        idle();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        reset_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            look();
            n_cmp++;
            if (sets !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset_sets got %b exp %b", sets, 5'b00000);
            end
            n_cmp++;
            if (ctl !== 5'b11010) begin
                n_bad++;
                $display("FAIL reset_ctl got %b exp %b", ctl, 5'b11010);
            end
            tick();
        end
        reset_in = 1'b0;
        look();
        n_cmp++;
        if (state_out !== 3'd0) begin
            n_bad++;
            $display("FAIL rel_state got %0d exp 0", state_out);
        end
        n_cmp++;
        if (stall_cnt_out !== 16'd0) begin
            n_bad++;
            $display("FAIL rel_stall got %0d exp 0", stall_cnt_out);
        end
        n_cmp++;
        if (sets !== 5'b11111 || ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL rel_out got %b/%b exp 11111/00000", sets, ctl);
        end
        tick();
    endtask

    task automatic test_load_use;
        do_reset();
        load_use_in = 1'b1;
        look();
        n_cmp++;
        if (sets !== 5'b00011 || ctl !== 5'b00100 || state_out !== 3'd0) begin
            n_bad++;
            $display("FAIL lu_hit got %b/%b/%0d exp 00011/00100/0",
                     sets, ctl, state_out);
        end
        tick();
        load_use_in = 1'b0;
        look();
        n_cmp++;
        if (sets !== 5'b11111 || ctl !== 5'b00000 || state_out !== 3'd0) begin
            n_bad++;
            $display("FAIL lu_after got %b/%b/%0d exp 11111/00000/0",
                     sets, ctl, state_out);
        end
        n_cmp++;
        if (stall_cnt_out !== 16'd1) begin
            n_bad++;
            $display("FAIL lu_stall got %0d exp 1", stall_cnt_out);
        end
        tick();
    endtask

    task automatic test_lsu_busy;
        do_reset();
        lsu_busy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            n_cmp++;
            if (sets !== 5'b00000 || ctl !== 5'b00010) begin
                n_bad++;
                $display("FAIL lsu_stall%0d got %b/%b exp 00000/00010",
                         i, sets, ctl);
            end
            n_cmp++;
            if (state_out !== ((i == 0) ? 3'd0 : 3'd2)) begin
                n_bad++;
                $display("FAIL lsu_state%0d got %0d exp %0d",
                         i, state_out, (i == 0) ? 0 : 2);
            end
            tick();
        end
        lsu_busy_in = 1'b0;
        look();
        n_cmp++;
        if (sets !== 5'b11111 || ctl !== 5'b00000 || state_out !== 3'd2) begin
            n_bad++;
            $display("FAIL lsu_release got %b/%b/%0d exp 11111/00000/2",
                     sets, ctl, state_out);
        end
        n_cmp++;
        if (stall_cnt_out !== 16'd3) begin
            n_bad++;
            $display("FAIL lsu_cnt got %0d exp 3", stall_cnt_out);
        end
        tick();
        look();
        n_cmp++;
        if (state_out !== 3'd0) begin
            n_bad++;
            $display("FAIL lsu_back got %0d exp 0", state_out);
        end
        tick();
    endtask

    task automatic test_bru_flush;
        do_reset();
        bru_flush_in = 1'b1;
        look();
        n_cmp++;
        if (sets !== 5'b11111 || ctl !== 5'b11000 || state_out !== 3'd0) begin
            n_bad++;
            $display("FAIL bru_hit got %b/%b/%0d exp 11111/11000/0",
                     sets, ctl, state_out);
        end
        tick();
        bru_flush_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            look();
            n_cmp++;
            if (sets !== 5'b11111 || ctl !== 5'b10000 || state_out !== 3'd3) begin
                n_bad++;
                $display("FAIL bru_flush%0d got %b/%b/%0d exp 11111/10000/3",
                         i, sets, ctl, state_out);
            end
            tick();
        end
        look();
        n_cmp++;
        if (ctl !== 5'b00000 || state_out !== 3'd0 || stall_cnt_out !== 16'd0) begin
            n_bad++;
            $display("FAIL bru_end got %b/%0d/%0d exp 00000/0/0",
                     ctl, state_out, stall_cnt_out);
        end
        tick();
    endtask

    task automatic test_bru_in_lsu;
        do_reset();
        lsu_busy_in = 1'b1;
        tick();
        bru_flush_in = 1'b1;
        look();
        n_cmp++;
        if (sets !== 5'b00000 || ctl !== 5'b00010 || state_out !== 3'd2) begin
            n_bad++;
            $display("FAIL bru_lsu got %b/%b/%0d exp 00000/00010/2",
                     sets, ctl, state_out);
        end
        tick();
        lsu_busy_in  = 1'b0;
        bru_flush_in = 1'b0;
        tick();
        look();
        n_cmp++;
        if (state_out !== 3'd0) begin
            n_bad++;
            $display("FAIL bru_lsu_after got %0d exp 0", state_out);
        end
        tick();
    endtask

    task automatic test_imem_bru;
        do_reset();
        imem_ready_in = 1'b0;
        look();
        n_cmp++;
        if (sets !== 5'b01111 || ctl !== 5'b10000 || state_out !== 3'd0) begin
            n_bad++;
            $display("FAIL imem_miss got %b/%b/%0d exp 01111/10000/0",
                     sets, ctl, state_out);
        end
        tick();
        bru_flush_in = 1'b1;
        look();
        n_cmp++;
        if (sets !== 5'b11111 || ctl !== 5'b11000 || state_out !== 3'd1) begin
            n_bad++;
            $display("FAIL imem_bru got %b/%b/%0d exp 11111/11000/1",
                     sets, ctl, state_out);
        end
        tick();
        bru_flush_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            look();
            n_cmp++;
            if (sets !== 5'b11111 || ctl !== 5'b10000 || state_out !== 3'd3) begin
                n_bad++;
                $display("FAIL imem_flush%0d got %b/%b/%0d exp 11111/10000/3",
                         i, sets, ctl, state_out);
            end
            tick();
        end
        imem_ready_in = 1'b1;
        look();
        n_cmp++;
        if (state_out !== 3'd0 || stall_cnt_out !== 16'd1) begin
            n_bad++;
            $display("FAIL imem_end got %0d/%0d exp 0/1",
                     state_out, stall_cnt_out);
        end
        tick();
    endtask

    task automatic test_halt_resume;
        do_reset();
        halt_req_in = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            look();
            n_cmp++;
            if (sets !== 5'b01111 || ctl !== 5'b10000 || state_out !== 3'd4) begin
                n_bad++;
                $display("FAIL drain%0d got %b/%b/%0d exp 01111/10000/4",
                         i, sets, ctl, state_out);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            look();
            n_cmp++;
            if (sets !== 5'b00000 || ctl !== 5'b00011 || state_out !== 3'd5) begin
                n_bad++;
                $display("FAIL halt%0d got %b/%b/%0d exp 00000/00011/5",
                         i, sets, ctl, state_out);
            end
            n_cmp++;
            if (stall_cnt_out !== 16'd4) begin
                n_bad++;
                $display("FAIL halt_cnt%0d got %0d exp 4", i, stall_cnt_out);
            end
            tick();
        end
        resume_in = 1'b1;
        tick();
        resume_in   = 1'b0;
        halt_req_in = 1'b0;
        look();
        n_cmp++;
        if (state_out !== 3'd0 || sets !== 5'b11111 || halted_out !== 1'b0) begin
            n_bad++;
            $display("FAIL resume got %0d/%b/%b exp 0/11111/0",
                     state_out, sets, halted_out);
        end
        tick();
    endtask

    task automatic test_saturation;
        do_reset();
        lsu_busy_in = 1'b1;
        repeat (65534) tick();
        look();
        n_cmp++;
        if (stall_cnt_out !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_pre got %h exp fffe", stall_cnt_out);
        end
        repeat (7) tick();
        look();
        n_cmp++;
        if (stall_cnt_out !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold got %h exp ffff", stall_cnt_out);
        end
        lsu_busy_in = 1'b0;
        tick();
    endtask

    // Reference: pipeline mode as independent countdowns/flags
    task automatic test_random;
        bit m_lsu;
        bit m_imem;
        bit m_halted;
        int flush_left;
        int drain_left;
        int m_stall;
        bit [4:0] e_sets;
        bit [4:0] e_ctl;
        bit [2:0] e_state;
        bit redirect;
        do_reset();
        m_lsu = 0;
        m_imem = 0;
        m_halted = 0;
        flush_left = 0;
        drain_left = 0;
        m_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            reset_in      = ($urandom_range(0, 99) == 0);
            imem_ready_in = ($urandom_range(0, 99) < 85);
            lsu_busy_in   = ($urandom_range(0, 99) < 12);
            load_use_in   = ($urandom_range(0, 99) < 10);
            bru_flush_in  = ($urandom_range(0, 99) < 8);
            resume_in     = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 19) == 0) halt_req_in = ~halt_req_in;
            e_sets   = 5'b11111;
            e_ctl    = 5'b00000;
            redirect = 0;
            if (m_halted) e_state = 3'd5;
            else if (m_lsu) e_state = 3'd2;
            else if (flush_left > 0) e_state = 3'd3;
            else if (drain_left > 0) e_state = 3'd4;
            else if (m_imem) e_state = 3'd1;
            else e_state = 3'd0;
            if (reset_in) begin
                e_sets = 5'b00000;
                e_ctl  = 5'b11010;
            end else if (m_halted) begin
                e_sets = 5'b00000;
                e_ctl  = 5'b00011;
            end else if (m_lsu) begin
                if (lsu_busy_in) begin
                    e_sets = 5'b00000;
                    e_ctl  = 5'b00010;
                end
            end else if (flush_left > 0) begin
                e_ctl = 5'b10000;
            end else if (drain_left > 0 || m_imem) begin
                if (bru_flush_in) begin
                    redirect = 1;
                    e_ctl    = 5'b11000;
                end else if (!(m_imem && imem_ready_in)) begin
                    e_sets = 5'b01111;
                    e_ctl  = 5'b10000;
                end
            end else if (bru_flush_in) begin
                redirect = 1;
                e_ctl    = 5'b11000;
            end else if (lsu_busy_in) begin
                e_sets = 5'b00000;
                e_ctl  = 5'b00010;
            end else if (load_use_in) begin
                e_sets = 5'b00011;
                e_ctl  = 5'b00100;
            end else if (!imem_ready_in) begin
                e_sets = 5'b01111;
                e_ctl  = 5'b10000;
            end
            look();
            n_cmp++;
            if (sets !== e_sets || ctl !== e_ctl) begin
                n_bad++;
                $display("FAIL rnd_out c=%0d got %b/%b exp %b/%b",
                         c, sets, ctl, e_sets, e_ctl);
            end
            n_cmp++;
            if (state_out !== e_state) begin
                n_bad++;
                $display("FAIL rnd_state c=%0d got %0d exp %0d",
                         c, state_out, e_state);
            end
            n_cmp++;
            if (stall_cnt_out !== 16'(m_stall)) begin
                n_bad++;
                $display("FAIL rnd_stall c=%0d got %0d exp %0d",
                         c, stall_cnt_out, m_stall);
            end
            if (reset_in) begin
                m_lsu = 0;
                m_imem = 0;
                m_halted = 0;
                flush_left = 0;
                drain_left = 0;
                m_stall = 0;
            end else begin
                if (!m_halted && e_sets != 5'b11111 && m_stall < 65535)
                    m_stall++;
                if (m_halted) begin
                    if (resume_in) m_halted = 0;
                end else if (m_lsu) begin
                    if (!lsu_busy_in) m_lsu = 0;
                end else if (flush_left > 0) begin
                    flush_left--;
                end else if (drain_left > 0) begin
                    if (redirect) drain_left = 4;
                    else if (drain_left == 1) begin
                        drain_left = 0;
                        m_halted = 1;
                    end else drain_left--;
                end else if (m_imem) begin
                    if (redirect) begin
                        m_imem = 0;
                        flush_left = 2;
                    end else if (imem_ready_in) m_imem = 0;
                end else if (redirect) begin
                    flush_left = 2;
                end else if (lsu_busy_in) begin
                    m_lsu = 1;
                end else if (load_use_in) begin
                    m_lsu = 0;
                end else if (!imem_ready_in) begin
                    m_imem = 1;
                end else if (halt_req_in) begin
                    drain_left = 4;
                end
            end
            tick();
        end
        idle();
        reset_in = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_in = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_lsu_busy();
        test_bru_flush();
        test_bru_in_lsu();
        test_imem_bru();
        test_halt_resume();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
